// File: rtl/register_file_module_if.sv
// -----------------------------------------------------------------------------
// register_file_module_if
// Bus bundle between the ALU/controller and the register file.
//   save        write enable, sampled on the rising clock edge
//   wr_addr     write address
//   alu_out     write data (ALU result)
//   rd_addr_a   read port A address
//   rd_addr_b   read port B address
//   data_out_a  read port A data (registered, 1-cycle latency)
//   data_out_b  read port B data (registered, 1-cycle latency)
//   clear       sweep-clear request
//   busy        high while a sweep-clear is running
// Modports: master = controller side, slave = register file side.
// -----------------------------------------------------------------------------
interface register_file_module_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 3
);
   logic              save;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  alu_out;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [WIDTH-1:0]  data_out_a;
   logic [WIDTH-1:0]  data_out_b;
   logic              clear;
   logic              busy;

   modport master (
      output save, wr_addr, alu_out, rd_addr_a, rd_addr_b, clear,
      input  data_out_a, data_out_b, busy
   );

   modport slave (
      input  save, wr_addr, alu_out, rd_addr_a, rd_addr_b, clear,
      output data_out_a, data_out_b, busy
   );
endinterface

// File: rtl/register_file_module.sv
// -----------------------------------------------------------------------------
// register_file_module
// DEPTH x WIDTH register file written from the ALU result bus, with two
// registered read ports feeding the ALU operands and a hardware sweep-clear
// that zeroes every entry (one per cycle) without a full reset.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (clears entries, outputs, FSM)
//   bus    register_file_module_if.slave (save/wr_addr/alu_out write port,
//          rd_addr_a/b -> data_out_a/b read ports, clear request, busy)
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a read of the entry being written returns the new data, and a
//               read of the entry being swept returns zero, on the same edge.
//   undefined : reads are read-before-write; no forwarding logic exists.
// -----------------------------------------------------------------------------
module register_file_module #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input logic                   clk,
   input logic                   reset,
   register_file_module_if.slave bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic              busy_r;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [WIDTH-1:0]  data_a;
   logic [WIDTH-1:0]  data_b;
   logic [WIDTH-1:0]  next_a;
   logic [WIDTH-1:0]  next_b;
   logic              wr_ok;

   // A write is only taken in IDLE, and a simultaneous clear request wins.
   assign wr_ok = (state == IDLE) && bus.save && !bus.clear;

   always_comb begin
      next_a = mem[bus.rd_addr_a];
      next_b = mem[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      // Present the value the entry will hold after this edge.
      if (wr_ok && (bus.rd_addr_a == bus.wr_addr)) begin
         next_a = bus.alu_out;
      end else if ((state == CLEAR) && (bus.rd_addr_a == ptr)) begin
         next_a = '0;
      end
      if (wr_ok && (bus.rd_addr_b == bus.wr_addr)) begin
         next_b = bus.alu_out;
      end else if ((state == CLEAR) && (bus.rd_addr_b == ptr)) begin
         next_b = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         data_a <= '0;
         data_b <= '0;
         state  <= IDLE;
         ptr    <= '0;
         busy_r <= 1'b0;
      end else begin
         // Read ports update every edge, including during a sweep.
         data_a <= next_a;
         data_b <= next_b;

         case (state)
            IDLE: begin
               if (bus.clear) begin
                  state  <= CLEAR;
                  ptr    <= '0;
                  busy_r <= 1'b1;
               end else if (wr_ok) begin
                  mem[bus.wr_addr] <= bus.alu_out;
               end
            end
            CLEAR: begin
               // save and clear are both ignored here; only the sweep writes.
               mem[ptr] <= '0;
               ptr      <= ptr + 1'b1;
               // The pointer wraps to 0 on the same edge the sweep finishes.
               if (ptr == ADDR_W'(DEPTH - 1)) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out_a = data_a;
   assign bus.data_out_b = data_b;
   assign bus.busy       = busy_r;

endmodule
